bram_sdp_arbiter: RTL and testbench

Shares one simple-dual-port block RAM (one write port, one synchronous read port) between two requesters, e.g. fetch-side and LSU-side table accessors. Reads and writes are arbitrated independently with round-robin fairness, so one read and one write can issue in the same cycle. Read responses return in order after the fixed RAM read latency, tagged back to the issuing master. A same-cycle read/write to the same address is forwarded so the read returns the new data.

---
 rtl/bram_sdp_arbiter.sv | 126 ++++++++++++
 tb/tb_bram_sdp_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_arbiter.sv
// rtl/bram_sdp_arbiter.sv - two-master round-robin arbiter for a simple-dual-port block RAM
// Reads and writes arbitrate independently; same-cycle read/write to one address is forwarded.
module bram_sdp_arbiter #(
  parameter int RAM_WIDTH    = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_req_valid,
  input  logic                  m0_req_we,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [RAM_WIDTH-1:0]  m0_req_wdata,
  output logic                  m0_req_ready,
  output logic                  m0_resp_valid,
  output logic [RAM_WIDTH-1:0]  m0_resp_rdata,
  input  logic                  m1_req_valid,
  input  logic                  m1_req_we,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [RAM_WIDTH-1:0]  m1_req_wdata,
  output logic                  m1_req_ready,
  output logic                  m1_resp_valid,
  output logic [RAM_WIDTH-1:0]  m1_resp_rdata,
  output logic [ADDR_WIDTH-1:0] bram_addr_w,
  output logic [RAM_WIDTH-1:0]  bram_din_w,
  output logic                  bram_we_w,
  output logic [ADDR_WIDTH-1:0] bram_addr_r,
  output logic                  bram_en_r,
  output logic                  bram_reg_ce_r,
  output logic                  bram_rst_r,
  input  logic [RAM_WIDTH-1:0]  bram_dout_r
);

  localparam int LAST = READ_LATENCY - 1;

  logic rd_c0, rd_c1, wr_c0, wr_c1;
  logic rd_g0, rd_g1, wr_g0, wr_g1;
  logic rd_sel1, wr_sel1;
  logic byp;
  logic rd_prio_q, rd_prio_d;
  logic wr_prio_q, wr_prio_d;
  logic [READ_LATENCY-1:0]                pv_q, pv_d;
  logic [READ_LATENCY-1:0]                pid_q, pid_d;
  logic [READ_LATENCY-1:0]                pb_q, pb_d;
  logic [READ_LATENCY-1:0][RAM_WIDTH-1:0] pd_q, pd_d;
  logic [RAM_WIDTH-1:0]                   rdata;
  logic                                   resp_v;

  // prio bit = 1 means master 1 wins contention
  always_comb begin
    rd_c0 = rstn & m0_req_valid & ~m0_req_we;
    rd_c1 = rstn & m1_req_valid & ~m1_req_we;
    wr_c0 = rstn & m0_req_valid & m0_req_we;
    wr_c1 = rstn & m1_req_valid & m1_req_we;
    rd_g0 = rd_c0 & (~rd_c1 | ~rd_prio_q);
    rd_g1 = rd_c1 & (~rd_c0 | rd_prio_q);
    wr_g0 = wr_c0 & (~wr_c1 | ~wr_prio_q);
    wr_g1 = wr_c1 & (~wr_c0 | wr_prio_q);
    rd_sel1 = rd_g1 | (~rd_g0 & rd_prio_q);
    wr_sel1 = wr_g1 | (~wr_g0 & wr_prio_q);

    m0_req_ready = rd_g0 | wr_g0;
    m1_req_ready = rd_g1 | wr_g1;
    bram_we_w    = wr_g0 | wr_g1;
    bram_addr_w  = wr_sel1 ? m1_req_addr : m0_req_addr;
    bram_din_w   = wr_sel1 ? m1_req_wdata : m0_req_wdata;
    bram_en_r    = rd_g0 | rd_g1;
    bram_addr_r  = rd_sel1 ? m1_req_addr : m0_req_addr;
    byp          = bram_we_w & bram_en_r & (bram_addr_w == bram_addr_r);

    rd_prio_d = rd_prio_q;
    if (rd_g0)      rd_prio_d = 1'b1;
    else if (rd_g1) rd_prio_d = 1'b0;
    wr_prio_d = wr_prio_q;
    if (wr_g0)      wr_prio_d = 1'b1;
    else if (wr_g1) wr_prio_d = 1'b0;
  end

  always_comb begin
    pv_d  = pv_q;
    pid_d = pid_q;
    pb_d  = pb_q;
    pd_d  = pd_q;
    pv_d[0]  = bram_en_r;
    pid_d[0] = rd_g1;
    pb_d[0]  = byp;
    pd_d[0]  = bram_din_w;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i]  = pv_q[i-1];
      pid_d[i] = pid_q[i-1];
      pb_d[i]  = pb_q[i-1];
      pd_d[i]  = pd_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_prio_q <= 1'b0;
      wr_prio_q <= 1'b0;
      pv_q      <= '0;
      pid_q     <= '0;
      pb_q      <= '0;
      pd_q      <= '0;
    end else begin
      rd_prio_q <= rd_prio_d;
      wr_prio_q <= wr_prio_d;
      pv_q      <= pv_d;
      pid_q     <= pid_d;
      pb_q      <= pb_d;
      pd_q      <= pd_d;
    end
  end

  // gating with rstn drops in-flight reads during the reset cycle itself
  always_comb begin
    rdata         = pb_q[LAST] ? pd_q[LAST] : bram_dout_r;
    resp_v        = pv_q[LAST] & rstn;
    m0_resp_valid = resp_v & ~pid_q[LAST];
    m1_resp_valid = resp_v & pid_q[LAST];
    m0_resp_rdata = m0_resp_valid ? rdata : '0;
    m1_resp_rdata = m1_resp_valid ? rdata : '0;
    bram_reg_ce_r = (READ_LATENCY == 2) ? (pv_q[0] & rstn) : 1'b0;
    bram_rst_r    = ~rstn;
  end

endmodule

// File: tb/tb_bram_sdp_arbiter.sv
// tb/tb_bram_sdp_arbiter.sv - scoreboard bench driving latency-1 and latency-2 arbiters in lockstep
module tb_bram_sdp_arbiter;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req_valid, m0_req_we, m1_req_valid, m1_req_we;
  logic [9:0]  m0_req_addr, m1_req_addr;
  logic [31:0] m0_req_wdata, m1_req_wdata;

  logic        a_rdy0, a_rdy1, a_rv0, a_rv1, a_we, a_en, a_ce, a_rst;
  logic [31:0] a_rd0, a_rd1, a_din, a_dout;
  logic [9:0]  a_aw, a_ar;
  logic        b_rdy0, b_rdy1, b_rv0, b_rv1, b_we, b_en, b_ce, b_rst;
  logic [31:0] b_rd0, b_rd1, b_din, b_dout, b_lat;
  logic [9:0]  b_aw, b_ar;

  logic [31:0] ram1 [1024];
  logic [31:0] ram2 [1024];
  logic [31:0] ref_mem [1024];
  exp_t        sb1[$];
  exp_t        sb2[$];
  int          total = 0, bad = 0, cyc = 0;
  logic        run = 1'b0;
  int          m_rd_prio = 0, m_wr_prio = 0;
  logic        prev_rd = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_sdp_arbiter #(.RAM_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(1)) u_a (
    .clk(clk), .rstn(rstn),
    .m0_req_valid(m0_req_valid), .m0_req_we(m0_req_we), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata), .m0_req_ready(a_rdy0), .m0_resp_valid(a_rv0), .m0_resp_rdata(a_rd0),
    .m1_req_valid(m1_req_valid), .m1_req_we(m1_req_we), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_req_ready(a_rdy1), .m1_resp_valid(a_rv1), .m1_resp_rdata(a_rd1),
    .bram_addr_w(a_aw), .bram_din_w(a_din), .bram_we_w(a_we), .bram_addr_r(a_ar), .bram_en_r(a_en),
    .bram_reg_ce_r(a_ce), .bram_rst_r(a_rst), .bram_dout_r(a_dout));

  bram_sdp_arbiter #(.RAM_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(2)) u_b (
    .clk(clk), .rstn(rstn),
    .m0_req_valid(m0_req_valid), .m0_req_we(m0_req_we), .m0_req_addr(m0_req_addr),
    .m0_req_wdata(m0_req_wdata), .m0_req_ready(b_rdy0), .m0_resp_valid(b_rv0), .m0_resp_rdata(b_rd0),
    .m1_req_valid(m1_req_valid), .m1_req_we(m1_req_we), .m1_req_addr(m1_req_addr),
    .m1_req_wdata(m1_req_wdata), .m1_req_ready(b_rdy1), .m1_resp_valid(b_rv1), .m1_resp_rdata(b_rd1),
    .bram_addr_w(b_aw), .bram_din_w(b_din), .bram_we_w(b_we), .bram_addr_r(b_ar), .bram_en_r(b_en),
    .bram_reg_ce_r(b_ce), .bram_rst_r(b_rst), .bram_dout_r(b_dout));

  // read-first block RAM models; the latency-2 one has a resettable output register
  always @(posedge clk) begin
    if (a_we) ram1[a_aw] <= a_din;
    if (a_en) a_dout <= ram1[a_ar];
    if (b_we) ram2[b_aw] <= b_din;
    if (b_en) b_lat <= ram2[b_ar];
    if (b_rst) b_dout <= 32'h0;
    else if (b_ce) b_dout <= b_lat;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic v0, input logic v1,
                     input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    int   sz;
    sz = (k == 1) ? sb1.size() : sb2.size();
    if (sz > 0) e = (k == 1) ? sb1[0] : sb2[0];
    chk($sformatf("lat%0d_dual_resp", k), {63'h0, v0 & v1}, 64'h0);
    if (!v0) chk($sformatf("lat%0d_m0_rdata_idle", k), {32'h0, d0}, 64'h0);
    if (!v1) chk($sformatf("lat%0d_m1_rdata_idle", k), {32'h0, d1}, 64'h0);
    if (v0 || v1) begin
      if (sz == 0) chk($sformatf("lat%0d_unexpected_resp", k), 64'h1, 64'h0);
      else begin
        if (k == 1) sb1.delete(0); else sb2.delete(0);
        chk($sformatf("lat%0d_resp_master", k), {63'h0, v1}, e.id);
        chk($sformatf("lat%0d_resp_data", k), {32'h0, v1 ? d1 : d0}, {32'h0, e.data});
        chk($sformatf("lat%0d_resp_cycle", k), cyc, e.due);
      end
    end else if (sz > 0 && e.due <= cyc) begin
      if (k == 1) sb1.delete(0); else sb2.delete(0);
      chk($sformatf("lat%0d_missing_resp", k), 64'h0, 64'h1);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      mon(1, a_rv0, a_rv1, a_rd0, a_rd1);
      mon(2, b_rv0, b_rv1, b_rd0, b_rd1);
    end
  end

  // one cycle: drive, check combinational grant outputs, advance the reference model
  task automatic step(input logic v0, input logic we0, input logic [9:0] a0, input logic [31:0] d0,
                      input logic v1, input logic we1, input logic [9:0] a1, input logic [31:0] d1,
                      input logic rst);
    int          rwin, wwin;
    logic [9:0]  ra, wa;
    logic [31:0] wd, rd;
    exp_t        e;
    m0_req_valid = v0; m0_req_we = we0; m0_req_addr = a0; m0_req_wdata = d0;
    m1_req_valid = v1; m1_req_we = we1; m1_req_addr = a1; m1_req_wdata = d1;
    rstn = ~rst;
    #3;
    rwin = -1; wwin = -1;
    if (!rst) begin
      if (v0 && !we0 && v1 && !we1) rwin = m_rd_prio;
      else if (v0 && !we0) rwin = 0;
      else if (v1 && !we1) rwin = 1;
      if (v0 && we0 && v1 && we1) wwin = m_wr_prio;
      else if (v0 && we0) wwin = 0;
      else if (v1 && we1) wwin = 1;
    end
    ra = (rwin == 1) ? a1 : a0;
    wa = (wwin == 1) ? a1 : a0;
    wd = (wwin == 1) ? d1 : d0;
    chk("ready0", {62'h0, a_rdy0, b_rdy0}, {62'h0, {2{rwin == 0 || wwin == 0}}});
    chk("ready1", {62'h0, a_rdy1, b_rdy1}, {62'h0, {2{rwin == 1 || wwin == 1}}});
    chk("bram_we_w", {62'h0, a_we, b_we}, {62'h0, {2{wwin >= 0}}});
    chk("bram_en_r", {62'h0, a_en, b_en}, {62'h0, {2{rwin >= 0}}});
    chk("bram_rst_r", {62'h0, a_rst, b_rst}, {62'h0, {2{rst}}});
    chk("reg_ce_lat1", {63'h0, a_ce}, 64'h0);
    chk("reg_ce_lat2", {63'h0, b_ce}, {63'h0, prev_rd && !rst});
    if (wwin >= 0) chk("write_addr_data", {22'h0, b_aw, b_din}, {22'h0, wa, wd});
    if (rwin >= 0) chk("read_addr", {54'h0, a_ar}, {54'h0, ra});
    if (rst) begin
      m_rd_prio = 0; m_wr_prio = 0;
      sb1.delete(); sb2.delete();
    end else begin
      if (rwin >= 0) begin
        rd = (wwin >= 0 && wa == ra) ? wd : ref_mem[ra];
        e.id = rwin; e.data = rd;
        e.due = cyc + 1; sb1.push_back(e);
        e.due = cyc + 2; sb2.push_back(e);
        m_rd_prio = 1 - rwin;
      end
      if (wwin >= 0) begin
        ref_mem[wa] = wd;
        m_wr_prio = 1 - wwin;
      end
    end
    prev_rd = (rwin >= 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    int m1, m2;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = i * 32'h9E3779B9;
    end
    ref_mem[5] = 32'hA5A5A5A5;
    ref_mem[3] = 32'h00000001;
    for (int i = 0; i < 1024; i++) begin
      ram1[i] = ref_mem[i];
      ram2[i] = ref_mem[i];
    end
    m0_req_valid = 0; m0_req_we = 0; m0_req_addr = 0; m0_req_wdata = 0;
    m1_req_valid = 0; m1_req_we = 0; m1_req_addr = 0; m1_req_wdata = 0;
    rstn = 1'b0;
    @(posedge clk); #1;
    run = 1'b1;
    do_reset(); do_reset();

    step(1, 0, 10'd5, 0, 0, 0, 0, 0, 0);
    idle(3);

    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 10'(i), 0, 1, 0, 10'(i + 20), 0, 0);
    idle(3);

    step(1, 1, 10'd7, 32'h12345678, 1, 0, 10'd7, 0, 0);
    idle(3);

    step(0, 0, 0, 0, 1, 0, 10'd3, 0, 0);
    step(1, 1, 10'd3, 32'h0000DEAD, 0, 0, 0, 0, 0);
    step(1, 0, 10'd3, 0, 0, 0, 0, 0, 0);
    idle(3);

    step(1, 0, 10'd9, 0, 0, 0, 0, 0, 0);
    do_reset();
    idle(3);
    step(1, 0, 10'd11, 0, 1, 0, 10'd12, 0, 0);
    idle(3);

    for (int i = 0; i < 800; i++) begin
      step(($urandom % 10) < 7, $urandom % 2, 10'($urandom_range(0, 15)), $urandom,
           ($urandom % 10) < 7, $urandom % 2, 10'($urandom_range(0, 15)), $urandom,
           ($urandom % 60) == 0);
    end
    idle(4);

    chk("lat1_queue_drained", sb1.size(), 64'h0);
    chk("lat2_queue_drained", sb2.size(), 64'h0);
    m1 = 0; m2 = 0;
    for (int i = 0; i < 1024; i++) begin
      if (ram1[i] !== ref_mem[i]) m1++;
      if (ram2[i] !== ref_mem[i]) m2++;
    end
    chk("lat1_ram_contents", m1, 64'h0);
    chk("lat2_ram_contents", m2, 64'h0);
    chk("ram7_written", {32'h0, ram1[7]}, {32'h0, ref_mem[7]});
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
